branch_target_predictor: RTL and testbench

Fetch-stage branch predictor and branch target buffer (BTB). It sits directly downstream of the loop detector. Its prediction combines the detector's `loop_decision`/`LD_en` with a per-entry 2-bit saturating counter, and it produces the predicted next PC for fetch. On branch resolution in EX it updates its tables, flags mispredictions, and supplies the recovery PC.

---
 rtl/branch_target_predictor.sv | 103 ++++++++++
 tb/tb_branch_target_predictor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Fetch-stage direction predictor plus branch target buffer. Predicts combinationally
// from PC_F, resolves and trains from the EX-stage outcome, and counts branches/mispredicts.
module branch_target_predictor #(
  parameter int WIDTH = 32,
  parameter int IDX   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC_F,
  input  logic             branch_en_F,
  input  logic             loop_decision,
  input  logic             LD_en,
  input  logic             branch_en_EX,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic [WIDTH-1:0] PC_destination,
  input  logic             feedback_from_ALU,
  input  logic             pred_taken_EX,
  input  logic [WIDTH-1:0] pred_target_EX,
  output logic             predict_taken_F,
  output logic [WIDTH-1:0] PC_predicted_F,
  output logic             mispredict_EX,
  output logic [WIDTH-1:0] PC_recover_EX,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  localparam int ENTRIES = 1 << IDX;
  localparam int TAG_W   = WIDTH - IDX - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX-1:0]   e_idx;
  logic             f_hit;
  logic             f_dir;

  // Word-alignment bits never select an entry.
  logic unused_align;
  assign unused_align = ^{PC_F[1:0], PC_EX[1:0]};

  assign f_idx = PC_F[IDX+1:2];
  assign f_tag = PC_F[WIDTH-1:IDX+2];
  assign e_idx = PC_EX[IDX+1:2];

  // Fetch path: the loop detector, when valid, overrides the counter's direction.
  assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_dir           = LD_en ? loop_decision : ctr_q[f_idx][1];
  assign predict_taken_F = branch_en_F && f_hit && f_dir;
  assign PC_predicted_F  = predict_taken_F ? target_q[f_idx] : PC_F + WIDTH'(4);

  // EX path: a taken branch is only correct if the carried target also matches.
  assign mispredict_EX = branch_en_EX &&
                         ((feedback_from_ALU != pred_taken_EX) ||
                          (feedback_from_ALU && (pred_target_EX != PC_destination)));
  assign PC_recover_EX = (branch_en_EX && feedback_from_ALU) ? PC_destination
                                                             : PC_EX + WIDTH'(4);

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mis_cnt_q;

  // NOTE: the table must be cleared by reset (not just its valid bits) because the
  // counters restart weakly not-taken; this costs a reset on every entry's storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        valid_q[k]  <= 1'b0;
        tag_q[k]    <= '0;
        target_q[k] <= '0;
        ctr_q[k]    <= 2'b01;
      end
    end else if (branch_en_EX) begin
      if (feedback_from_ALU) begin
        // A tag conflict replaces the entry but keeps training the shared counter.
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= PC_EX[WIDTH-1:IDX+2];
        target_q[e_idx] <= PC_destination;
        if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
      end else begin
        if (ctr_q[e_idx] != 2'b00) ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, which is also what gives fetch the old entry on a same-index write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (branch_en_EX) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict_EX && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and
// randomized traffic compared against a table-of-entries reference model.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC_F = '0;
  logic        branch_en_F = 1'b0;
  logic        loop_decision = 1'b0;
  logic        LD_en = 1'b0;
  logic        branch_en_EX = 1'b0;
  logic [31:0] PC_EX = '0;
  logic [31:0] PC_destination = '0;
  logic        feedback_from_ALU = 1'b0;
  logic        pred_taken_EX = 1'b0;
  logic [31:0] pred_target_EX = '0;
  logic        predict_taken_F;
  logic [31:0] PC_predicted_F;
  logic        mispredict_EX;
  logic [31:0] PC_recover_EX;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_target_predictor #(.WIDTH(32), .IDX(6)) dut (
    .clk(clk), .rst(rst),
    .PC_F(PC_F), .branch_en_F(branch_en_F),
    .loop_decision(loop_decision), .LD_en(LD_en),
    .branch_en_EX(branch_en_EX), .PC_EX(PC_EX),
    .PC_destination(PC_destination), .feedback_from_ALU(feedback_from_ALU),
    .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
    .predict_taken_F(predict_taken_F), .PC_predicted_F(PC_predicted_F),
    .mispredict_EX(mispredict_EX), .PC_recover_EX(PC_recover_EX),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One EX resolution followed by one fetch lookup in the next cycle.
  typedef struct {
    bit          ex_en;
    logic [31:0] pc_ex;
    logic [31:0] dest;
    bit          taken;
    bit          ptk;
    logic [31:0] ptgt;
    bit          exp_mis;
    logic [31:0] exp_rec;
    bit          bf;
    logic [31:0] pc_f;
    bit          ld_en;
    bit          ld;
    bit          exp_ptk;
    logic [31:0] exp_pred;
  } vec_t;

  vec_t vec[15];

  // Reference model: an array of BTB entries, trained from the outcome rules.
  typedef struct {
    bit          valid;
    int unsigned tag;
    int unsigned tgt;
    int          ctr;
  } entry_t;

  entry_t      m_tab[64];
  longint unsigned m_br, m_mis;

  function automatic void model_reset();
    for (int k = 0; k < 64; k++) m_tab[k] = '{1'b0, 0, 0, 1};
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic bit model_mis();
    return branch_en_EX && ((feedback_from_ALU != pred_taken_EX) ||
                            (feedback_from_ALU && pred_target_EX != PC_destination));
  endfunction

  function automatic void model_update();
    int j;
    if (!branch_en_EX) return;
    j = (PC_EX / 4) % 64;
    if (model_mis()) m_mis++;
    m_br++;
    if (feedback_from_ALU) begin
      m_tab[j].valid = 1'b1;
      m_tab[j].tag   = PC_EX / 256;
      m_tab[j].tgt   = PC_destination;
      if (m_tab[j].ctr < 3) m_tab[j].ctr++;
    end else if (m_tab[j].ctr > 0) begin
      m_tab[j].ctr--;
    end
  endfunction

  task automatic model_compare();
    int    i;
    bit    hit, dir, ptk;
    logic [31:0] pred, rec;
    i    = (PC_F / 4) % 64;
    hit  = m_tab[i].valid && (m_tab[i].tag == PC_F / 256);
    dir  = LD_en ? loop_decision : (m_tab[i].ctr >= 2);
    ptk  = branch_en_F && hit && dir;
    pred = ptk ? m_tab[i].tgt : PC_F + 32'd4;
    rec  = (branch_en_EX && feedback_from_ALU) ? PC_destination : PC_EX + 32'd4;
    check("rnd_predict_taken", {63'd0, predict_taken_F}, {63'd0, ptk});
    check("rnd_pc_predicted", {32'd0, PC_predicted_F}, {32'd0, pred});
    check("rnd_mispredict", {63'd0, mispredict_EX}, {63'd0, model_mis()});
    check("rnd_pc_recover", {32'd0, PC_recover_EX}, {32'd0, rec});
    check("rnd_branch_count", {32'd0, branch_count}, m_br);
    check("rnd_mispredict_count", {32'd0, mispredict_count}, m_mis);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
  endfunction

  initial begin
    //        ex  pc_ex         dest   T  ptk ptgt   mis rec           bf pc_f          lde ld ptk pred
    vec[0]  = '{1, 32'h100,      32'h80, 1, 0, 32'h0,  1, 32'h80,       1, 32'h100,      0, 0, 1, 32'h80};
    vec[1]  = '{1, 32'h100,      32'h80, 1, 1, 32'h80, 0, 32'h80,       1, 32'h100,      0, 0, 1, 32'h80};
    vec[2]  = '{1, 32'h100,      32'h80, 1, 1, 32'h80, 0, 32'h80,       1, 32'h100,      0, 0, 1, 32'h80};
    vec[3]  = '{1, 32'h100,      32'h80, 1, 1, 32'h80, 0, 32'h80,       1, 32'h100,      0, 0, 1, 32'h80};
    vec[4]  = '{1, 32'h100,      32'h80, 1, 1, 32'h80, 0, 32'h80,       1, 32'h100,      0, 0, 1, 32'h80};
    vec[5]  = '{1, 32'h100,      32'h80, 0, 1, 32'h80, 1, 32'h104,      1, 32'h100,      0, 0, 1, 32'h80};
    vec[6]  = '{1, 32'h100,      32'h80, 0, 1, 32'h80, 1, 32'h104,      1, 32'h100,      0, 0, 0, 32'h104};
    vec[7]  = '{0, 32'h300,      32'h0,  0, 0, 32'h0,  0, 32'h304,      1, 32'h100,      1, 1, 1, 32'h80};
    vec[8]  = '{1, 32'h100,      32'h80, 1, 0, 32'h0,  1, 32'h80,       1, 32'h100,      1, 0, 0, 32'h104};
    vec[9]  = '{1, 32'h100,      32'h80, 1, 1, 32'h80, 0, 32'h80,       1, 32'h100,      0, 0, 1, 32'h80};
    vec[10] = '{0, 32'h0,        32'h0,  0, 0, 32'h0,  0, 32'h4,        1, 32'h100,      1, 0, 0, 32'h104};
    vec[11] = '{1, 32'h200,      32'h40, 1, 0, 32'h0,  1, 32'h40,       1, 32'h100,      0, 0, 0, 32'h104};
    vec[12] = '{1, 32'h200,      32'h40, 1, 1, 32'h80, 1, 32'h40,       1, 32'h200,      0, 0, 1, 32'h40};
    vec[13] = '{0, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0,  0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0};
    vec[14] = '{0, 32'h0,        32'h0,  0, 0, 32'h0,  0, 32'h4,        0, 32'h200,      0, 0, 0, 32'h204};

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    PC_F = 32'h100; branch_en_F = 1'b1;
    #1;
    check("reset_predict_taken", {63'd0, predict_taken_F}, 64'd0);
    check("reset_pc_predicted", {32'd0, PC_predicted_F}, 64'h104);
    check("reset_branch_count", {32'd0, branch_count}, 64'd0);
    check("reset_mispredict_count", {32'd0, mispredict_count}, 64'd0);

    foreach (vec[i]) begin
      branch_en_F = 1'b0; LD_en = 1'b0; loop_decision = 1'b0;
      branch_en_EX = vec[i].ex_en; PC_EX = vec[i].pc_ex;
      PC_destination = vec[i].dest; feedback_from_ALU = vec[i].taken;
      pred_taken_EX = vec[i].ptk; pred_target_EX = vec[i].ptgt;
      #1;
      check($sformatf("vec%0d_mispredict", i), {63'd0, mispredict_EX}, {63'd0, vec[i].exp_mis});
      check($sformatf("vec%0d_recover", i), {32'd0, PC_recover_EX}, {32'd0, vec[i].exp_rec});
      @(posedge clk); #1;
      branch_en_EX = 1'b0;
      branch_en_F = vec[i].bf; PC_F = vec[i].pc_f;
      LD_en = vec[i].ld_en; loop_decision = vec[i].ld;
      #1;
      check($sformatf("vec%0d_predict_taken", i), {63'd0, predict_taken_F}, {63'd0, vec[i].exp_ptk});
      check($sformatf("vec%0d_pc_predicted", i), {32'd0, PC_predicted_F}, {32'd0, vec[i].exp_pred});
    end
    check("table_branch_count", {32'd0, branch_count}, 64'd11);
    check("table_mispredict_count", {32'd0, mispredict_count}, 64'd6);

    // Same-cycle resolve and fetch of one index: fetch sees the old (aliased) entry.
    branch_en_EX = 1'b1; PC_EX = 32'h100; PC_destination = 32'h80;
    feedback_from_ALU = 1'b1; pred_taken_EX = 1'b0; pred_target_EX = 32'h0;
    branch_en_F = 1'b1; PC_F = 32'h100; LD_en = 1'b0;
    #1;
    check("rw_old_predict_taken", {63'd0, predict_taken_F}, 64'd0);
    check("rw_old_pc_predicted", {32'd0, PC_predicted_F}, 64'h104);
    @(posedge clk); #1;
    branch_en_EX = 1'b0;
    #1;
    check("rw_new_predict_taken", {63'd0, predict_taken_F}, 64'd1);
    check("rw_new_pc_predicted", {32'd0, PC_predicted_F}, 64'h80);

    // Mispredict counter saturation.
    force dut.mis_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.mis_cnt_q;
    branch_en_EX = 1'b1; PC_EX = 32'h100; feedback_from_ALU = 1'b0;
    pred_taken_EX = 1'b1; pred_target_EX = 32'h80;
    #1;
    check("sat_mispredict_pre", {32'd0, mispredict_count}, 64'hFFFF_FFFF);
    @(posedge clk); #1;
    branch_en_EX = 1'b0;
    check("sat_mispredict_hold", {32'd0, mispredict_count}, 64'hFFFF_FFFF);
    check("sat_branch_count", {32'd0, branch_count}, 64'd13);

    // Asynchronous reset between edges clears tables and counters at once.
    PC_F = 32'h100; branch_en_F = 1'b1; LD_en = 1'b0;
    #1;
    check("prereset_predict_taken", {63'd0, predict_taken_F}, 64'd1);
    rst = 1'b0;
    #1;
    check("midreset_predict_taken", {63'd0, predict_taken_F}, 64'd0);
    check("midreset_pc_predicted", {32'd0, PC_predicted_F}, 64'h104);
    check("midreset_branch_count", {32'd0, branch_count}, 64'd0);
    check("midreset_mispredict_count", {32'd0, mispredict_count}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      PC_F = rnd_pc();
      branch_en_F = ($urandom_range(0, 3) != 0);
      LD_en = ($urandom_range(0, 3) == 0);
      loop_decision = $urandom_range(0, 1);
      branch_en_EX = ($urandom_range(0, 3) != 0);
      PC_EX = rnd_pc();
      feedback_from_ALU = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: PC_destination = 32'h40;
        1: PC_destination = 32'h80;
        2: PC_destination = 32'hC0;
        default: PC_destination = $urandom;
      endcase
      pred_taken_EX = $urandom_range(0, 1);
      pred_target_EX = ($urandom_range(0, 1) != 0) ? PC_destination : 32'h80;
      #1;
      model_compare();
      model_update();
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
